// File: rtl/seq_fill_ctrl.sv
// Sequence-fill controller: pulls words from the LFSR and writes them into the
// sequence memory, either refilling every entry or appending a single one.
module seq_fill_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              clr_len,
  input  logic              rng_done,
  input  logic [DATA_W-1:0] rng_data,
  output logic              rng_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   seq_len,
  output logic              full
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              full_c;

  assign full_c = (len_q == LEN_W'(DEPTH));

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update; seq_len only moves in WRITE or on a clear.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    mode_d  = mode_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (!mode) begin
            ptr_d   = '0;
            state_d = S_REQ;
          end else if (!full_c) begin
            ptr_d   = ADDR_W'(len_q);
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (clr_len) begin
          len_d = '0;
        end
      end
      S_REQ: begin
        if (rng_done) begin
          wdata_d = rng_data;
          waddr_d = ptr_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mode_q) begin
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            len_d   = LEN_W'(DEPTH);
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_REQ;
          end
        end else begin
          len_d   = len_q + LEN_W'(1);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rng_en    = (state_q == S_REQ);
  assign mem_we    = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign seq_len   = len_q;
  assign full      = full_c;

endmodule

// File: tb/tb_seq_fill_ctrl.sv
// Randomised scoreboard bench for seq_fill_ctrl: an LFSR responder feeds words,
// a reference model predicts writes and completions, a monitor compares them.
module tb_seq_fill_ctrl;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct packed { logic err; logic [LEN_W-1:0] len; } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, mode, clr_len, rng_done;
  logic [DATA_W-1:0] rng_data;
  logic rng_en, mem_we, busy, done, err, full;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LEN_W-1:0]  seq_len;

  logic start5, mode5, clr5, rng_done5;
  logic [7:0] rng_data5;
  logic rng_en5, mem_we5, busy5, done5, err5, full5;
  logic [2:0] mem_waddr5;
  logic [7:0] mem_wdata5;
  logic [3:0] seq_len5;

  always #5 clk = ~clk;

  seq_fill_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .clr_len(clr_len),
    .rng_done(rng_done), .rng_data(rng_data), .rng_en(rng_en), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .seq_len(seq_len), .full(full));

  seq_fill_ctrl #(.DATA_W(8), .DEPTH(5), .ADDR_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode5), .clr_len(clr5),
    .rng_done(rng_done5), .rng_data(rng_data5), .rng_en(rng_en5), .mem_we(mem_we5),
    .mem_waddr(mem_waddr5), .mem_wdata(mem_wdata5), .busy(busy5), .done(done5),
    .err(err5), .seq_len(seq_len5), .full(full5));

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wr_seen = 0;
  int n5 = 0;
  int model_len = 0;
  int dmin = 0, dmax = 0, dly_sum = 0;
  bit noise = 1'b0;
  bit armed = 1'b0;
  int wl = 0;
  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] fixed_q[$];
  wr_t   exp_wr[$];
  done_t exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // LFSR responder: answers each request after a random stall, optional noise outside REQ.
  always @(negedge clk) begin
    if (!rst_n) begin
      armed = 1'b0;
      rng_done = 1'b0;
    end else if (rng_en) begin
      if (!armed) begin
        armed = 1'b1;
        wl = $urandom_range(dmax, dmin);
        dly_sum += wl;
      end
      if (wl == 0) begin
        armed = 1'b0;
        rng_done = 1'b1;
        rng_data = (fixed_q.size() != 0) ? fixed_q.pop_front() : DATA_W'($urandom);
        if (addr_q.size() == 0) chk("unexpected_rng_req", 32'(rng_en), 32'd0);
        else exp_wr.push_back('{a: addr_q.pop_front(), d: rng_data});
      end else begin
        rng_done = 1'b0;
        wl--;
      end
    end else begin
      armed = 1'b0;
      rng_done = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      rng_data = DATA_W'($urandom);
    end
  end

  // Monitor: compares every write and completion against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    done_t ed;
    if (rst_n) begin
      if (mem_we) begin
        wr_seen++;
        chk("rng_en_low_in_write", 32'(rng_en), 32'd0);
        if (exp_wr.size() == 0) chk("unexpected_write", 32'(mem_we), 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_waddr), 32'(e.a));
          chk("wr_data", 32'(mem_wdata), 32'(e.d));
        end
      end
      if (err && !done) chk("err_without_done", 32'(err), 32'd0);
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          ed = exp_done.pop_front();
          chk("done_err", 32'(err), 32'(ed.err));
          chk("done_len", 32'(seq_len), 32'(ed.len));
          chk("done_full", 32'(full), 32'(ed.len == LEN_W'(DEPTH)));
        end
      end
      if (mem_we5) begin
        chk("d5_addr", 32'(mem_waddr5), 32'(n5));
        n5++;
      end
    end
  end

  task automatic do_op(input logic m, input bit with_clr, input bit noisy);
    int c0, lat, nwr;
    bit rej, got;
    @(negedge clk);
    dly_sum = 0;
    lat = -1;
    nwr = 0;
    rej = m && (model_len == int'(DEPTH));
    if (!m) begin
      for (int i = 0; i < int'(DEPTH); i++) addr_q.push_back(ADDR_W'(i));
      nwr = DEPTH;
      model_len = DEPTH;
    end else if (!rej) begin
      addr_q.push_back(ADDR_W'(model_len));
      model_len++;
      nwr = 1;
    end
    exp_done.push_back('{err: rej, len: LEN_W'(model_len)});
    start = 1'b1;
    mode = m;
    clr_len = with_clr;
    c0 = cyc + 1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rng_en_after_start", 32'(rng_en), 32'(!rej));
      end
      if (done) begin
        got = 1'b1;
        lat = cyc - c0;
        start = 1'b0;
        clr_len = 1'b0;
        mode = 1'b0;
      end else begin
        start = noisy && ($urandom_range(3, 0) == 0);
        mode = 1'($urandom);
        clr_len = noisy && ($urandom_range(1, 0) == 1);
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(dly_sum + 2 * nwr));
    @(negedge clk);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    start = 1'b0;
    clr_len = 1'b1;
    model_len = 0;
    @(negedge clk);
    clr_len = 1'b0;
    chk("clr_len_zero", 32'(seq_len), 32'd0);
  endtask

  initial begin
    int w0;
    bit hit;
    start = 0; mode = 0; clr_len = 0; rng_data = '0;
    start5 = 0; mode5 = 0; clr5 = 0; rng_done5 = 1; rng_data5 = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rng_en", 32'(rng_en), 32'd0);
    chk("rst_seq_len", 32'(seq_len), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    // Directed fill with rng_done effectively held high.
    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_op(1'b0, 1'b0, 1'b0);

    // Reset during the REQ of entry 2 of a stalled fill.
    dmin = 2; dmax = 2;
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) addr_q.push_back(ADDR_W'(i));
    w0 = wr_seen;
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (wr_seen == w0 + 2 && rng_en) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reached_entry2_req", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rng_en", 32'(rng_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_seq_len", 32'(seq_len), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_we_done_err", 32'({mem_we, done, err}), 32'd0);
    addr_q.delete(); exp_wr.delete(); exp_done.delete();
    model_len = 0;
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_seen;
    repeat (10) @(negedge clk);
    chk("no_write_after_reset", 32'(wr_seen), 32'(w0));

    // Stalled fill, 3 cycles per word, with stray start/clr/rng_done pulses.
    dmin = 3; dmax = 3; noise = 1'b1;
    w0 = wr_seen;
    do_op(1'b0, 1'b0, 1'b1);
    chk("stall_fill_writes", 32'(wr_seen - w0), 32'(DEPTH));

    // Clear then four appends, then a rejected fifth.
    dmin = 0; dmax = 0; noise = 1'b0;
    do_clr();
    fixed_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0);

    // start + clr_len together: start wins, so the append is still rejected.
    do_op(1'b1, 1'b1, 1'b0);
    do_clr();
    do_op(1'b1, 1'b1, 1'b0);

    // Randomised mix of operations.
    noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dmax = $urandom_range(3, 0);
      if ($urandom_range(4, 0) == 0) do_clr();
      else do_op(1'($urandom_range(2, 0) != 0), 1'($urandom), 1'b1);
    end
    noise = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_wr.size() + exp_done.size() + addr_q.size()), 32'd0);

    // DEPTH=5 instance: fill covers addresses 0..4 only.
    n5 = 0;
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (done5) hit = 1'b1;
      else @(negedge clk);
    end
    chk("d5_done_seen", 32'(hit), 32'd1);
    chk("d5_writes", 32'(n5), 32'd5);
    chk("d5_seq_len", 32'(seq_len5), 32'd5);
    chk("d5_full", 32'(full5), 32'd1);
    repeat (4) @(negedge clk);
    chk("d5_no_extra_writes", 32'(n5), 32'd5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
